mult_scheduler: RTL and testbench
=================================

MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter WIDTH, default 3: operand width in bits; product width is 2*WIDTH.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req0  input  1  requester 0 asks for a multiply; held high until gnt0.
REQ-006 A0, B0  input  WIDTH each  requester 0 operands; valid while req0 is high.
REQ-007 req1  input  1  requester 1 request; same rules as req0.
REQ-008 A1, B1  input  WIDTH each  requester 1 operands.
REQ-009 gnt0, gnt1  output  1 each  one-cycle pulse: operands of that requester captured.
REQ-010 busy  output  1  high from the gnt cycle through the done cycle inclusive.
REQ-011 P  output  2*WIDTH  product of the last completed operation; held until the next done.
REQ-012 done  output  1  one-cycle pulse: P is newly valid.
REQ-013 done_id  output  1  requester that owns the current P: 0 or 1; updated with done, held otherwise.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-015 Arbitration SHALL occur only in IDLE.
  - Sampled req0=1, req1=0: grant 0.
  - Sampled req0=0, req1=1: grant 1.
  - Both high: grant the requester not served last (round-robin pointer).
REQ-016 On the grant edge the block SHALL:
  - latch the granted requester's operands;
  - clear the accumulator and the step counter;
  - drive the matching gnt high for exactly one cycle;
  - go to CALC.
REQ-017 CALC SHALL last exactly WIDTH cycles. Each cycle it SHALL perform one shift-add step:
  - if multiplier LSB = 1, acc += multiplicand (width 2*WIDTH, no overflow possible);
  - multiplicand <<= 1;
  - multiplier >>= 1;
  - counter += 1.
REQ-018 After the WIDTH-th step the FSM SHALL go to DONE. In DONE it SHALL:
  - register P = acc;
  - pulse done for one cycle and set done_id;
  - toggle the round-robin pointer to the served id;
  - return to IDLE.
REQ-019 Latency: done SHALL assert exactly WIDTH+1 cycles after the gnt cycle. Minimum issue interval is WIDTH+2 cycles.
REQ-020 Requests while busy SHALL NOT be granted. They are considered at the first IDLE cycle after DONE.
REQ-021 A request deasserted before its grant SHALL be dropped silently; no gnt, no done.
REQ-022 Operand changes after gnt SHALL NOT affect the result.
REQ-023 Zero operands SHALL still take the full WIDTH+1 latency and produce P = 0.

Reset
REQ-024 On rst assertion, in any state including mid-CALC, the block SHALL immediately:
  - enter IDLE;
  - clear acc, counter and operand registers;
  - force P = 0, done = 0, done_id = 0, gnt0 = gnt1 = 0, busy = 0;
  - set the pointer so requester 0 wins the first tie.
REQ-025 An operation aborted by reset SHALL produce no done.
REQ-026 The first grant SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-027 A shared package mult_pkg SHALL hold:
  - the FSM state enum (IDLE, CALC, DONE);
  - default WIDTH = 3;
  - requester id constants ID0 = 0 and ID1 = 1.
REQ-028 The shift-add datapath (operand registers, accumulator, step counter, done_step flag) SHALL be the sub-module shift_add_mult. It is controlled by load/step strobes from mult_scheduler.
REQ-029 Arbitration and FSM SHALL remain in mult_scheduler.

Verification
REQ-030 Single request: req0, A0=7, B0=7 -> gnt0 pulse; done 4 cycles later with P=49 (6'b110001), done_id=0; busy high for 5 cycles.
REQ-031 Tie after reset: req0 (3,3) and req1 (4,2) both held -> gnt0 first, P=9, done_id=0; then gnt1, P=8, done_id=1.
REQ-032 Fairness: both requests held high continuously for 6 operations -> grants alternate 0,1,0,1,0,1; no gnt within 5 cycles of the previous gnt.
REQ-033 Busy hold-off: req1 (2,1) raised during the CALC of req0 (1,1) -> done P=1, done_id=0, then gnt1 at the first IDLE cycle, then P=2, done_id=1.
REQ-034 Reset mid-CALC: rst pulsed during the second CALC cycle of (5,6) -> no done; P=0; a subsequent (5,6) request yields P=30.
REQ-035 Zero and operand stability: A0=0, B0=5, with A0 changed to 7 after gnt0 -> P=0 after exactly 4 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiply scheduler.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam int DEF_WIDTH = 3;

   localparam logic ID0 = 1'b0;
   localparam logic ID1 = 1'b1;

endpackage

// File: rtl/mult_scheduler_if.sv
// Requester / result bundle between the two clients and the scheduler.
interface mult_scheduler_if
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);

   logic                 req0;
   logic                 req1;
   logic [WIDTH-1:0]     A0;
   logic [WIDTH-1:0]     B0;
   logic [WIDTH-1:0]     A1;
   logic [WIDTH-1:0]     B1;
   logic                 gnt0;
   logic                 gnt1;
   logic                 busy;
   logic [2*WIDTH-1:0]   P;
   logic                 done;
   logic                 done_id;

   modport master (
      output req0, req1, A0, B0, A1, B1,
      input  gnt0, gnt1, busy, P, done, done_id
   );

   modport slave (
      input  req0, req1, A0, B0, A1, B1,
      output gnt0, gnt1, busy, P, done, done_id
   );

endinterface

// File: rtl/shift_add_mult.sv
// Sequential shift-add datapath: one partial product per step strobe.
module shift_add_mult
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] acc,
   output logic               done_step
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + CW'(1);
      end
   end

   // High on the step that completes the last partial product.
   assign done_step = step && (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin arbiter and IDLE/CALC/DONE sequencer for two multiply clients.
module mult_scheduler
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   mult_scheduler_if.slave bus
);

   state_t             state;
   logic               last;
   logic               cur;
   logic               any;
   logic               pick1;
   logic               load;
   logic               step;
   logic               done_step;
   logic [WIDTH-1:0]   a_sel;
   logic [WIDTH-1:0]   b_sel;
   logic [2*WIDTH-1:0] acc;
   logic               gnt0_q;
   logic               gnt1_q;
   logic               busy_q;
   logic               done_q;
   logic               done_id_q;
   logic [2*WIDTH-1:0] p_q;

   // A tie goes to whoever was not served last.
   assign any   = bus.req0 | bus.req1;
   assign pick1 = bus.req1 & (~bus.req0 | (last == ID0));
   assign a_sel = pick1 ? bus.A1 : bus.A0;
   assign b_sel = pick1 ? bus.B1 : bus.B0;
   assign load  = (state == IDLE) & any;
   assign step  = (state == CALC);

   shift_add_mult #(.WIDTH(WIDTH)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .step      (step),
      .a         (a_sel),
      .b         (b_sel),
      .acc       (acc),
      .done_step (done_step)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         last      <= ID1;
         cur       <= ID0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         done_id_q <= ID0;
         p_q       <= '0;
      end else begin
         gnt0_q <= 1'b0;
         gnt1_q <= 1'b0;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               busy_q <= any;
               if (any) begin
                  state  <= CALC;
                  cur    <= pick1;
                  gnt0_q <= ~pick1;
                  gnt1_q <= pick1;
               end
            end
            CALC: begin
               if (done_step) state <= DONE;
            end
            DONE: begin
               p_q       <= acc;
               done_q    <= 1'b1;
               done_id_q <= cur;
               last      <= cur;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt0    = gnt0_q;
   assign bus.gnt1    = gnt1_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.done_id = done_id_q;
   assign bus.P       = p_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized and directed checks of mult_scheduler against a transaction-level model.
module tb_mult_scheduler;
   import mult_pkg::*;

   localparam int W = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mult_scheduler_if #(.WIDTH(W)) bus ();

   mult_scheduler #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Model: timing expressed in edge numbers, product computed arithmetically.
   int edge_n   = 0;
   int next_arb = 1;
   int g_edge   = -1;
   int d_edge   = -1;
   int prod     = 0;
   bit g_id     = 0;
   int m_p      = 0;
   bit m_id     = 0;
   bit last     = 1;

   bit         pend [2];
   logic [W-1:0] oa [2];
   logic [W-1:0] ob [2];

   task automatic chk(string tag, int got, int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive();
      bus.req0 = pend[0];
      bus.A0   = oa[0];
      bus.B0   = ob[0];
      bus.req1 = pend[1];
      bus.A1   = oa[1];
      bus.B1   = ob[1];
   endtask

   task automatic request(int i, int a, int b);
      pend[i] = 1'b1;
      oa[i]   = W'(a);
      ob[i]   = W'(b);
      drive();
   endtask

   task automatic model_reset();
      next_arb = edge_n + 1;
      g_edge   = -1;
      d_edge   = -1;
      m_p      = 0;
      m_id     = 0;
      last     = 1;
   endtask

   task automatic model_edge();
      bit r0;
      bit r1;
      r0 = pend[0];
      r1 = pend[1];
      edge_n++;
      if (edge_n >= next_arb && (r0 || r1)) begin
         g_id     = (r0 && r1) ? ~last : r1;
         g_edge   = edge_n;
         d_edge   = edge_n + W + 1;
         next_arb = edge_n + W + 2;
         prod     = int'(oa[g_id]) * int'(ob[g_id]);
         pend[g_id] = 1'b0;
      end
      if (edge_n == d_edge) begin
         m_p  = prod;
         m_id = g_id;
         last = g_id;
      end
   endtask

   task automatic check_outputs();
      bit in_op;
      in_op = (g_edge >= 0) && (edge_n >= g_edge) && (edge_n <= d_edge);
      chk("gnt0", int'(bus.gnt0), int'(edge_n == g_edge && g_id == 0));
      chk("gnt1", int'(bus.gnt1), int'(edge_n == g_edge && g_id == 1));
      chk("busy", int'(bus.busy), int'(in_op));
      chk("done", int'(bus.done), int'(edge_n == d_edge));
      chk("P", int'(bus.P), m_p);
      chk("done_id", int'(bus.done_id), int'(m_id));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      #2;
      rst = 1'b0;
   endtask

   // mode 0: hold stimulus, 1: random traffic, 2: both clients always requesting
   task automatic cycle(int mode);
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         if (mode == 1) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               oa[i]   = W'($urandom);
               ob[i]   = W'($urandom);
            end else if (pend[i] && $urandom_range(0, 15) == 0) begin
               pend[i] = 1'b0;
            end else if (!pend[i]) begin
               oa[i] = W'($urandom);
               ob[i] = W'($urandom);
            end
         end else if (mode == 2 && !pend[i]) begin
            pend[i] = 1'b1;
            oa[i]   = W'($urandom);
            ob[i]   = W'($urandom);
         end
      end
      if (mode == 1 && $urandom_range(0, 199) == 0) do_reset();
      drive();
   endtask

   task automatic run(int n, int mode);
      for (int k = 0; k < n; k++) cycle(mode);
   endtask

   initial begin
      rst = 1'b1;
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      oa[0] = '0; ob[0] = '0;
      oa[1] = '0; ob[1] = '0;
      drive();
      #1;
      check_outputs();
      @(negedge clk);
      rst = 1'b0;

      // single request 7*7
      request(0, 7, 7);
      run(8, 0);
      chk("single_p49", int'(bus.P), 49);
      chk("single_id", int'(bus.done_id), 0);

      // tie right after reset: 0 first, then 1
      @(negedge clk);
      do_reset();
      request(0, 3, 3);
      request(1, 4, 2);
      run(6, 0);
      chk("tie_first_p", int'(bus.P), 9);
      run(6, 0);
      chk("tie_second_p", int'(bus.P), 8);
      chk("tie_second_id", int'(bus.done_id), 1);

      // fairness with both clients saturating
      run(6 * (W + 2) + 2, 2);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive();
      run(8, 0);

      // request raised while busy
      request(0, 1, 1);
      run(2, 0);
      request(1, 2, 1);
      run(12, 0);
      chk("holdoff_p", int'(bus.P), 2);

      // reset during the second CALC cycle
      request(0, 5, 6);
      run(2, 0);
      do_reset();
      run(6, 0);
      chk("abort_p", int'(bus.P), 0);
      request(0, 5, 6);
      run(7, 0);
      chk("after_abort_p", int'(bus.P), 30);

      // zero operand, operand changed after grant
      request(0, 0, 5);
      run(1, 0);
      oa[0] = W'(7);
      drive();
      run(6, 0);
      chk("zero_p", int'(bus.P), 0);

      run(3000, 1);
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      drive();
      run(8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
